// File: rtl/mult_div_ctrl.sv
// Iterative 32x32 signed multiply (radix-2 Booth) with an optional restoring divider.
// Define MULT_DIV_CTRL_DIV_EN to build the divide path (start_div, DIV state, div_zero).
module mult_div_ctrl #(
  localparam int unsigned XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_mult,
  input  logic            start_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            hi_we,
  output logic            lo_we,
  output logic            div_zero
);

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     acc_hi_q, acc_hi_d;
  logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
  logic [XLEN-1:0]   m_q, m_d;
  logic              qm1_q, qm1_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hi_we_q, hi_we_d;
  logic              lo_we_q, lo_we_d;
  logic [XLEN:0]     booth_sum;

`ifdef MULT_DIV_CTRL_DIV_EN
  logic              div_zero_q, div_zero_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
`endif

  // Next-state, datapath step and registered-output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    hi_we_d   = 1'b0;
    lo_we_d   = 1'b0;
    booth_sum = acc_hi_q;
`ifdef MULT_DIV_CTRL_DIV_EN
    div_zero_d = 1'b0;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_shift  = {acc_hi_q[XLEN-1:0], acc_lo_q[XLEN-1]};
    div_trial  = div_shift - {1'b0, m_q};
`endif

    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          acc_hi_d = '0;
          acc_lo_d = op_b;
          m_d      = op_a;
          qm1_d    = 1'b0;
          cnt_d    = '0;
          state_d  = S_MULT;
        end
`ifdef MULT_DIV_CTRL_DIV_EN
        else if (start_div) begin
          if (op_b == '0) begin
            // Divide by zero: flag only, result registers untouched
            state_d    = S_DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = op_a[XLEN-1] ? XLEN'(-op_a) : op_a;
            m_d      = op_b[XLEN-1] ? XLEN'(-op_b) : op_b;
            q_neg_d  = op_a[XLEN-1] ^ op_b[XLEN-1];
            r_neg_d  = op_a[XLEN-1];
            cnt_d    = '0;
            state_d  = S_DIV;
          end
        end
`endif
      end

      S_MULT: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = S_DONE;
          hi_d    = acc_hi_q[XLEN-1:0];
          lo_d    = acc_lo_q;
          done_d  = 1'b1;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
        end else begin
          case ({acc_lo_q[0], qm1_q})
            2'b01:   booth_sum = acc_hi_q + {m_q[XLEN-1], m_q};
            2'b10:   booth_sum = acc_hi_q - {m_q[XLEN-1], m_q};
            default: booth_sum = acc_hi_q;
          endcase
          acc_hi_d = {booth_sum[XLEN], booth_sum[XLEN:1]};
          acc_lo_d = {booth_sum[0], acc_lo_q[XLEN-1:1]};
          qm1_d    = acc_lo_q[0];
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

`ifdef MULT_DIV_CTRL_DIV_EN
      S_DIV: begin
        if (cnt_q == CNT_W'(XLEN)) begin
          state_d = S_DONE;
          lo_d    = q_neg_q ? XLEN'(-acc_lo_q) : acc_lo_q;
          hi_d    = r_neg_q ? XLEN'(-acc_hi_q[XLEN-1:0]) : acc_hi_q[XLEN-1:0];
          done_d  = 1'b1;
          hi_we_d = 1'b1;
          lo_we_d = 1'b1;
        end else begin
          // Restoring step: keep the trial difference only when it did not borrow
          if (!div_trial[XLEN]) begin
            acc_hi_d = div_trial;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_we_q  <= 1'b0;
      lo_we_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      qm1_q    <= qm1_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_we_q  <= hi_we_d;
      lo_we_q  <= lo_we_d;
    end
  end

`ifdef MULT_DIV_CTRL_DIV_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_zero_q <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
    end
  end

  assign div_zero = div_zero_q;
`else
  logic unused_start_div;
  assign unused_start_div = start_div;
  assign div_zero = 1'b0;
`endif

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign hi_we = hi_we_q;
  assign lo_we = lo_we_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl (divide tests follow MULT_DIV_CTRL_DIV_EN).
module tb_mult_div_ctrl;

  logic        clock;
  logic        reset;
  logic        start_mult;
  logic        start_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        hi_we;
  logic        lo_we;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  mult_div_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .div_zero   (div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue one start at the current negedge and observe the completion; lat=-1 if no done within 40 edges.
  task automatic exec_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                         output logic rhwe, output logic rlwe, output logic rdz,
                         output logic busy_mid, output logic idle_after);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    start_div  = 1'b0;
    busy_mid   = busy;
    lat        = -1;
    if (done) lat = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (k == inj) begin
        start_mult = 1'b1;
        start_div  = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      start_mult = 1'b0;
      start_div  = 1'b0;
      if (done) lat = k;
    end
    rhi  = hi;
    rlo  = lo;
    rhwe = hi_we;
    rlwe = lo_we;
    rdz  = div_zero;
    @(posedge clock);
    @(negedge clock);
    idle_after = !busy && !done;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    start_mult = 1'b0;
    start_div  = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if ({hi_we, lo_we, div_zero} !== 3'b000)
      begin errors++; $display("FAIL reset_strobes: got %b want 000", {hi_we, lo_we, div_zero}); end
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int lat; logic [31:0] rhi, rlo; logic rhwe, rlwe, rdz, bm, ia;
    exec_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 33)           begin errors++; $display("FAIL mul7_latency: got %0d want 33", lat); end
    checks++; if (rhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul7_hi: got %h want ffffffff", rhi); end
    checks++; if (rlo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul7_lo: got %h want ffffffeb", rlo); end
    checks++; if ({rhwe, rlwe, rdz} !== 3'b110)
      begin errors++; $display("FAIL mul7_strobes: got %b want 110", {rhwe, rlwe, rdz}); end
    checks++; if (bm !== 1'b1)          begin errors++; $display("FAIL mul7_busy: got %b want 1", bm); end
    checks++; if (ia !== 1'b1)          begin errors++; $display("FAIL mul7_idle_after: got %b want 1", ia); end
    exec_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (rhi !== 32'h4000_0000) begin errors++; $display("FAIL mulmin_hi: got %h want 40000000", rhi); end
    checks++; if (rlo !== 32'h0)         begin errors++; $display("FAIL mulmin_lo: got %h want 0", rlo); end
    exec_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if ({rhi, rlo} !== 64'h1)  begin errors++; $display("FAIL mulneg_prod: got %h want 1", {rhi, rlo}); end
    // hi after this product (0x1234 * 0x100000001) also seeds the divide-by-zero check
    exec_op(1'b1, 1'b0, 32'd2987060, 32'd6700417, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if ({rhi, rlo} !== 64'h0000_1234_0000_1234)
      begin errors++; $display("FAIL mulbig_prod: got %h want 0000123400001234", {rhi, rlo}); end
  endtask

  task automatic test_both_starts();
    int lat; logic [31:0] rhi, rlo; logic rhwe, rlwe, rdz, bm, ia;
    exec_op(1'b1, 1'b1, 32'd3, 32'd5, 10, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 33)    begin errors++; $display("FAIL both_latency: got %0d want 33", lat); end
    checks++; if (rhi !== 32'h0) begin errors++; $display("FAIL both_hi: got %h want 0", rhi); end
    checks++; if (rlo !== 32'd15) begin errors++; $display("FAIL both_lo: got %h want f", rlo); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rhi, rlo; logic rhwe, rlwe, rdz, bm, ia;
    exec_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd9, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    exec_op(1'b1, 1'b0, 32'd100000, 32'd300000, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if ({rhi, rlo} !== 64'd30000000000)
      begin errors++; $display("FAIL b2b_prod: got %h want 6fc23ac00", {rhi, rlo}); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] rhi, rlo; logic rhwe, rlwe, rdz, bm, ia;
`ifdef MULT_DIV_CTRL_DIV_EN
    exec_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 33)            begin errors++; $display("FAIL div7_latency: got %0d want 33", lat); end
    checks++; if (rlo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div7_lo: got %h want fffffffd", rlo); end
    checks++; if (rhi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div7_hi: got %h want ffffffff", rhi); end
    exec_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (rlo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo: got %h want 80000000", rlo); end
    checks++; if ({rhi, rdz} !== 33'h0)  begin errors++; $display("FAIL divmin_hi_flag: got %h want 0", {rhi, rdz}); end
    exec_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (rlo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div100_lo: got %h want fffffff2", rlo); end
    checks++; if (rhi !== 32'd2)         begin errors++; $display("FAIL div100_hi: got %h want 2", rhi); end
    exec_op(1'b1, 1'b0, 32'd2987060, 32'd6700417, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    exec_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 0)   begin errors++; $display("FAIL divz_latency: got %0d want 0", lat); end
    checks++; if ({rdz, rhwe, rlwe} !== 3'b100)
      begin errors++; $display("FAIL divz_flags: got %b want 100", {rdz, rhwe, rlwe}); end
    checks++; if ({rhi, rlo} !== 64'h0000_1234_0000_1234)
      begin errors++; $display("FAIL divz_hold: got %h want 0000123400001234", {rhi, rlo}); end
    checks++; if (ia !== 1'b1) begin errors++; $display("FAIL divz_idle_after: got %b want 1", ia); end
`else
    exec_op(1'b1, 1'b0, 32'd2987060, 32'd6700417, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    exec_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== -1)  begin errors++; $display("FAIL nodiv_done: got latency %0d want none", lat); end
    checks++; if (bm !== 1'b0) begin errors++; $display("FAIL nodiv_busy: got %b want 0", bm); end
    checks++; if ({rhi, rlo} !== 64'h0000_1234_0000_1234)
      begin errors++; $display("FAIL nodiv_hold: got %h want 0000123400001234", {rhi, rlo}); end
    exec_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if ({lat == -1, rdz} !== 2'b10)
      begin errors++; $display("FAIL nodiv_zero: got latency %0d flag %b want none/0", lat, rdz); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rhi, rlo; logic rhwe, rlwe, rdz, bm, ia;
    logic saw_done;
    start_mult = 1'b1;
    op_a       = 32'd7;
    op_b       = 32'd3;
    @(posedge clock);
    @(negedge clock);
    start_mult = 1'b0;
    repeat (16) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, done, hi_we, lo_we, div_zero} !== 5'b0)
      begin errors++; $display("FAIL rstmid_ctrl: got %b want 00000", {busy, done, hi_we, lo_we, div_zero}); end
    checks++; if ({hi, lo} !== 64'h0)
      begin errors++; $display("FAIL rstmid_data: got %h want 0", {hi, lo}); end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_abort: got activity %b want 0", saw_done); end
    exec_op(1'b1, 1'b0, 32'd7, 32'd3, 0, lat, rhi, rlo, rhwe, rlwe, rdz, bm, ia);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rstmid_restart_latency: got %0d want 33", lat); end
    checks++; if ({rhi, rlo} !== 64'd21)
      begin errors++; $display("FAIL rstmid_restart_prod: got %h want 15", {rhi, rlo}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_both_starts();
    test_back_to_back();
    test_div();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 The port list SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous active-low reset
- start_mult  in  1  single-cycle request: signed multiply op_a*op_b
- start_div  in  1  single-cycle request: signed divide op_a/op_b
- op_a  in  32  multiplicand / dividend
- op_b  in  32  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- hi_we  out  1  HI register write strobe
- lo_we  out  1  LO register write strobe
- div_zero  out  1  one-cycle divide-by-zero flag

Function
REQ-003 The FSM SHALL have four states: IDLE, MULT, DIV, DONE.
REQ-004 In IDLE, a start sampled high SHALL latch op_a/op_b, clear the iteration counter, and move to MULT or DIV.
REQ-005 If start_mult and start_div are sampled high together, multiply SHALL win and start_div SHALL be dropped.
REQ-006 Starts sampled outside IDLE SHALL be ignored, with no queuing.
REQ-007 MULT SHALL perform a radix-2 signed Booth multiply: one iteration per cycle, 32 iterations, 64-bit two's-complement result.
REQ-008 DIV SHALL perform a restoring divide on the operand magnitudes: one iteration per cycle, 32 iterations.
REQ-009 Division results: quotient sign = sign(op_a) XOR sign(op_b); remainder sign = sign(op_a).
REQ-010 The divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-011 After the 32nd iteration the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
REQ-012 In DONE: done=1, hi_we=1, lo_we=1, and hi/lo SHALL carry the result.
REQ-013 Latency: done SHALL be high in the cycle following the 33rd rising edge after the edge that sampled start.
REQ-014 If op_b==0 at a sampled start_div, the FSM SHALL go directly to DONE.
REQ-015 In that DONE cycle: done=1, div_zero=1, hi_we=0, lo_we=0, and hi/lo SHALL keep their previous values.
REQ-016 busy SHALL be high in MULT, DIV and DONE, and low in IDLE.
REQ-017 hi/lo SHALL hold the last result until the next DONE.
REQ-018 Outside DONE, done, hi_we, lo_we and div_zero SHALL be 0.
REQ-019 A start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-020 reset low SHALL immediately force IDLE and clear the counter and operand latches.
REQ-021 During reset: hi=0, lo=0, busy=0, done=0, hi_we=0, lo_we=0, div_zero=0.
REQ-022 Reset asserted mid-operation SHALL abort it, with no done and no write strobes.
REQ-023 After reset release, the first clock edge SHALL be able to sample a start.

Configuration
REQ-024 Macro MULT_DIV_CTRL_DIV_EN defined: the DIV state, divider datapath and div_zero SHALL be implemented per REQ-008..REQ-015.
REQ-025 Macro MULT_DIV_CTRL_DIV_EN undefined: start_div SHALL be ignored, DIV and the divider SHALL not be synthesized, div_zero SHALL be tied to 0, and multiply behaviour SHALL be unchanged.

Verification
REQ-026 start_mult, op_a=7, op_b=0xFFFFFFFD -> 33 edges later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB, hi_we=lo_we=1.
REQ-027 start_mult, op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-028 start_div, op_a=0xFFFFFFF9, op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; with macro undefined -> no busy, no done.
REQ-029 start_div, op_b=0 (prior hi=lo=0x1234) -> next cycle done=1, div_zero=1, no write strobes, hi=lo=0x1234.
REQ-030 start_mult and start_div together (op_a=3, op_b=5) -> multiply result hi=0, lo=15; a start_div pulsed at cycle 10 is ignored.
REQ-031 reset low at iteration 16 of a multiply -> all outputs 0, IDLE, no done; new start_mult after release completes normally.
